// File: rtl/vector_mem_pkg.sv
// Shared types for the vector data-memory arbiter: FSM state and grant source.
package vector_mem_pkg;

  localparam int DEF_DATA_WIDTH  = 19;
  localparam int DEF_VECTOR_SIZE = 6;
  localparam int WORD_WIDTH      = DEF_DATA_WIDTH * DEF_VECTOR_SIZE;

  typedef enum logic {
    CPU_PRI    = 1'b0,
    HOST_BURST = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_HOST = 2'd2
  } gnt_src_t;

endpackage

// File: rtl/mem_port_mux.sv
// Memory-port steering: picks the CPU or host request for the single memory port.
module mem_port_mux
  import vector_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 19,
  parameter int WORD_W        = WORD_WIDTH
) (
  input  logic [1:0]               gnt_i,
  input  logic                     cpuWe_i,
  input  logic [ADDRESS_WIDTH-1:0] cpuAddr_i,
  input  logic [WORD_W-1:0]        cpuWdata_i,
  input  logic                     hostWe_i,
  input  logic [ADDRESS_WIDTH-1:0] hostAddr_i,
  input  logic [WORD_W-1:0]        hostWdata_i,
  output logic                     memWe_o,
  output logic [ADDRESS_WIDTH-1:0] memAddr_o,
  output logic [WORD_W-1:0]        memWdata_o
);

  // An idle port drives all zeros so the memory never sees a stray write.
  always_comb begin
    memWe_o    = 1'b0;
    memAddr_o  = '0;
    memWdata_o = '0;
    case (gnt_src_t'(gnt_i))
      GNT_CPU: begin
        memWe_o    = cpuWe_i;
        memAddr_o  = cpuAddr_i;
        memWdata_o = cpuWdata_i;
      end
      GNT_HOST: begin
        memWe_o    = hostWe_i;
        memAddr_o  = hostAddr_i;
        memWdata_o = hostWdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vector_mem_arbiter.sv
// CPU-priority arbiter for the vector data memory port, with host anti-starvation
// (saturating wait counter) and bounded host burst lock.
module vector_mem_arbiter
  import vector_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 19,
  parameter int VECTOR_SIZE   = 6,
  parameter int ADDRESS_WIDTH = 19,
  parameter int MAX_WAIT      = 4,
  parameter int MAX_BURST     = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              cpuReq,
  input  logic                              cpuWe,
  input  logic [ADDRESS_WIDTH-1:0]          cpuAddr,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] cpuWdata,
  output logic [DATA_WIDTH*VECTOR_SIZE-1:0] cpuRdata,
  output logic                              cpuStall,
  input  logic                              hostReq,
  input  logic                              hostLock,
  input  logic                              hostWe,
  input  logic [ADDRESS_WIDTH-1:0]          hostAddr,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] hostWdata,
  output logic                              hostGrant,
  output logic                              hostRvalid,
  output logic [DATA_WIDTH*VECTOR_SIZE-1:0] hostRdata,
  output logic                              memWe,
  output logic [ADDRESS_WIDTH-1:0]          memAddr,
  output logic [DATA_WIDTH*VECTOR_SIZE-1:0] memWdata,
  input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] memRdata
);

  localparam int WW  = DATA_WIDTH * VECTOR_SIZE;
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam int BCW = $clog2(MAX_BURST + 1);

  localparam logic [WCW-1:0] WAIT_SAT  = WCW'(MAX_WAIT);
  localparam logic [BCW-1:0] BURST_MAX = BCW'(MAX_BURST);
  // A one-grant burst is just an ordinary grant, so never enter the lock state.
  localparam logic           BURST_EN  = (MAX_BURST > 1);

  arb_state_t     state_q, state_d;
  logic [WCW-1:0] waitCnt_q, waitCnt_d;
  logic [BCW-1:0] burstCnt_q, burstCnt_d;
  logic           hostRvalid_q;
  logic [WW-1:0]  hostRdata_q;
  gnt_src_t       gnt;

  always_comb begin
    gnt        = GNT_NONE;
    state_d    = state_q;
    burstCnt_d = burstCnt_q;
    if (reset) begin
      case (state_q)
        CPU_PRI: begin
          if (hostReq && waitCnt_q == WAIT_SAT) gnt = GNT_HOST;
          else if (cpuReq)                      gnt = GNT_CPU;
          else if (hostReq)                     gnt = GNT_HOST;
          if (BURST_EN && gnt == GNT_HOST && hostLock) begin
            state_d    = HOST_BURST;
            burstCnt_d = BCW'(1);
          end
        end
        HOST_BURST: begin
          if (hostReq) begin
            gnt        = GNT_HOST;
            burstCnt_d = burstCnt_q + 1'b1;
          end
          // The grant that reaches the limit is still performed this cycle.
          if (!hostReq || !hostLock || burstCnt_d == BURST_MAX) state_d = CPU_PRI;
        end
        default: state_d = CPU_PRI;
      endcase
    end
  end

  assign hostGrant = (gnt == GNT_HOST);
  assign cpuStall  = reset & cpuReq & (gnt != GNT_CPU);
  assign cpuRdata  = memRdata;

  always_comb begin
    waitCnt_d = '0;
    if (hostReq && !hostGrant)
      waitCnt_d = (waitCnt_q == WAIT_SAT) ? waitCnt_q : waitCnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= CPU_PRI;
      waitCnt_q    <= '0;
      burstCnt_q   <= '0;
      hostRvalid_q <= 1'b0;
      hostRdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      burstCnt_q   <= burstCnt_d;
      hostRvalid_q <= hostGrant & ~hostWe;
      if (hostGrant && !hostWe) hostRdata_q <= memRdata;
    end
  end

  assign hostRvalid = hostRvalid_q;
  assign hostRdata  = hostRdata_q;

  mem_port_mux #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .WORD_W       (WW)
  ) u_mux (
    .gnt_i      (gnt),
    .cpuWe_i    (cpuWe),
    .cpuAddr_i  (cpuAddr),
    .cpuWdata_i (cpuWdata),
    .hostWe_i   (hostWe),
    .hostAddr_i (hostAddr),
    .hostWdata_i(hostWdata),
    .memWe_o    (memWe),
    .memAddr_o  (memAddr),
    .memWdata_o (memWdata)
  );

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Bench for vector_mem_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of the arbitration rules.
module tb_vector_mem_arbiter;

  localparam int DW = 19;
  localparam int VS = 6;
  localparam int AW = 19;
  localparam int MW = 4;
  localparam int MB = 8;
  localparam int WW = DW * VS;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpuReq, cpuWe, hostReq, hostLock, hostWe;
  logic [AW-1:0] cpuAddr, hostAddr;
  logic [WW-1:0] cpuWdata, hostWdata, cpuRdata, hostRdata, memWdata, memRdata;
  logic          cpuStall, hostGrant, hostRvalid, memWe;
  logic [AW-1:0] memAddr;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  vector_mem_arbiter #(
    .DATA_WIDTH(DW), .VECTOR_SIZE(VS), .ADDRESS_WIDTH(AW),
    .MAX_WAIT(MW), .MAX_BURST(MB)
  ) dut (
    .clock(clock), .reset(reset),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .cpuRdata(cpuRdata), .cpuStall(cpuStall),
    .hostReq(hostReq), .hostLock(hostLock), .hostWe(hostWe), .hostAddr(hostAddr),
    .hostWdata(hostWdata), .hostGrant(hostGrant), .hostRvalid(hostRvalid),
    .hostRdata(hostRdata), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata)
  );

  // Memory instance: combinational read, write at the edge; preload port for setup.
  logic [WW-1:0] mem [0:255];
  logic          pre_we = 1'b0;
  logic [7:0]    pre_addr = '0;
  logic [WW-1:0] pre_data = '0;
  assign memRdata = mem[memAddr[7:0]];
  always @(posedge clock) begin
    if (memWe) mem[memAddr[7:0]] <= memWdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  // Reference model state
  logic [WW-1:0] ref_mem [0:255];
  int            m_wait, m_bcnt;
  bit            m_burst;
  logic          m_rv;
  logic [WW-1:0] m_rd;
  logic          e_hg, e_cs, e_we, e_cg;
  logic [AW-1:0] e_addr;
  logic [WW-1:0] e_wd, e_crd;

  function automatic logic [WW-1:0] rand_word();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[WW-1:0];
  endfunction

  function automatic logic [WW-1:0] wdat(int k);
    logic [DW-1:0] e;
    e = DW'(k * 7 + 3);
    return {VS{e}};
  endfunction

  task automatic model_eval();
    e_hg = 1'b0; e_cs = 1'b0; e_we = 1'b0; e_cg = 1'b0; e_addr = '0; e_wd = '0;
    if (reset) begin
      if (m_burst)                       e_hg = hostReq;
      else if (hostReq && m_wait == MW)  e_hg = 1'b1;
      else if (cpuReq)                   e_cg = 1'b1;
      else if (hostReq)                  e_hg = 1'b1;
      e_cs = cpuReq && !e_cg;
      if (e_cg) begin e_we = cpuWe; e_addr = cpuAddr; e_wd = cpuWdata; end
      else if (e_hg) begin e_we = hostWe; e_addr = hostAddr; e_wd = hostWdata; end
    end
    e_crd = ref_mem[e_addr[7:0]];
  endtask

  task automatic model_commit();
    if (!reset) begin
      m_wait = 0; m_bcnt = 0; m_burst = 0; m_rv = 1'b0; m_rd = '0;
    end else begin
      m_rv = e_hg && !hostWe;
      if (m_rv) m_rd = ref_mem[hostAddr[7:0]];
      if (!m_burst) begin
        if (e_hg && hostLock && MB > 1) begin m_burst = 1; m_bcnt = 1; end
      end else if (e_hg) begin
        m_bcnt++;
        if (!hostLock || m_bcnt == MB) m_burst = 0;
      end else m_burst = 0;
      m_wait = (hostReq && !e_hg) ? ((m_wait < MW) ? m_wait + 1 : MW) : 0;
      if (e_we) ref_mem[e_addr[7:0]] = e_wd;
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic step();
    model_commit();
    @(negedge clock);
  endtask

  task automatic preload(input int a, input logic [WW-1:0] d);
    reset = 1'b0; pre_we = 1'b1; pre_addr = 8'(a); pre_data = d;
    ref_mem[a] = d;
    settle();
    step();
    pre_we = 1'b0;
  endtask

  task automatic reset_cycle();
    reset = 1'b0;
    settle();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; cpuReq = 1; hostReq = 1; hostWe = 0; hostLock = 1; cpuWe = 1;
    cpuAddr = AW'(5); hostAddr = AW'(6);
    settle();
    checks++; if (hostGrant !== 1'b0) begin failures++; $display("FAIL reset_hostGrant got=%0b exp=0", hostGrant); end
    checks++; if (cpuStall !== 1'b0) begin failures++; $display("FAIL reset_cpuStall got=%0b exp=0", cpuStall); end
    checks++; if (memWe !== 1'b0) begin failures++; $display("FAIL reset_memWe got=%0b exp=0", memWe); end
    checks++; if (memAddr !== '0) begin failures++; $display("FAIL reset_memAddr got=%h exp=0", memAddr); end
    checks++; if (memWdata !== '0) begin failures++; $display("FAIL reset_memWdata got=%h exp=0", memWdata); end
    step();
    settle();
    checks++; if (hostRvalid !== 1'b0) begin failures++; $display("FAIL reset_hostRvalid got=%0b exp=0", hostRvalid); end
    checks++; if (hostRdata !== '0) begin failures++; $display("FAIL reset_hostRdata got=%h exp=0", hostRdata); end
    step();
    reset = 1'b1; cpuWe = 0;
    settle();
    checks++; if (hostGrant !== 1'b0 || cpuStall !== 1'b0) begin failures++; $display("FAIL release_cpu_first hg=%0b cs=%0b exp 0/0", hostGrant, cpuStall); end
    checks++; if (memAddr !== AW'(5)) begin failures++; $display("FAIL release_memAddr got=%h exp=5", memAddr); end
    step();
  endtask

  task automatic test_contention();
    logic exp_h;
    reset_cycle();
    reset = 1'b1; cpuReq = 1; cpuWe = 0; cpuAddr = AW'(8'h41);
    hostReq = 1; hostWe = 1; hostLock = 0; hostAddr = AW'(8'h40); hostWdata = wdat(40);
    for (int c = 0; c < 10; c++) begin
      settle();
      exp_h = (c == 4 || c == 9);
      checks++; if (hostGrant !== exp_h || cpuStall !== exp_h) begin failures++; $display("FAIL contention_c%0d hg=%0b cs=%0b exp=%0b", c, hostGrant, cpuStall, exp_h); end
      checks++; if (memAddr !== (exp_h ? AW'(8'h40) : AW'(8'h41))) begin failures++; $display("FAIL contention_addr_c%0d got=%h", c, memAddr); end
      step();
    end
    hostReq = 0; cpuReq = 0;
  endtask

  task automatic test_host_read();
    logic [DW-1:0] el;
    logic [WW-1:0] pat;
    el = DW'(12'hABC);
    pat = {VS{el}};
    preload(8'h10, pat);
    reset = 1'b1; cpuReq = 0; hostReq = 1; hostWe = 0; hostLock = 0; hostAddr = AW'(8'h10);
    settle();
    checks++; if (hostGrant !== 1'b1 || memAddr !== AW'(8'h10)) begin failures++; $display("FAIL hostread_grant hg=%0b addr=%h exp 1/10", hostGrant, memAddr); end
    step();
    hostReq = 0;
    settle();
    checks++; if (hostRvalid !== 1'b1) begin failures++; $display("FAIL hostread_rvalid got=%0b exp=1", hostRvalid); end
    checks++; if (hostRdata !== pat) begin failures++; $display("FAIL hostread_rdata got=%h exp=%h", hostRdata, pat); end
    step();
    settle();
    checks++; if (hostRvalid !== 1'b0 || hostRdata !== pat) begin failures++; $display("FAIL hostread_hold rv=%0b rd=%h", hostRvalid, hostRdata); end
    step();
  endtask

  task automatic test_burst();
    int k;
    int gcyc [10];
    int exp_c;
    reset_cycle();
    reset = 1'b1; cpuReq = 1; cpuWe = 0; cpuAddr = AW'(8'h30);
    hostLock = 1; hostWe = 1; k = 0;
    for (int cyc = 0; cyc < 60 && k < 10; cyc++) begin
      hostReq = 1; hostAddr = AW'(k); hostWdata = wdat(k);
      settle();
      if (hostGrant === 1'b1) begin
        gcyc[k] = cyc;
        checks++; if (cpuStall !== 1'b1) begin failures++; $display("FAIL burst_stall_k%0d got=%0b exp=1", k, cpuStall); end
        k++;
      end
      step();
    end
    hostReq = 0; cpuReq = 0;
    checks++; if (k != 10) begin failures++; $display("FAIL burst_timeout grants=%0d exp=10", k); end
    for (int i = 0; i < k; i++) begin
      exp_c = (i < 8) ? 4 + i : ((i == 8) ? 16 : 17);
      checks++; if (gcyc[i] != exp_c) begin failures++; $display("FAIL burst_gcyc_%0d got=%0d exp=%0d", i, gcyc[i], exp_c); end
      checks++; if (mem[i] !== wdat(i)) begin failures++; $display("FAIL burst_mem_%0d got=%h exp=%h", i, mem[i], wdat(i)); end
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int a = 0; a < 4; a++) preload(a, '0);
    reset = 1'b1; cpuReq = 0; cpuWe = 0; hostReq = 1; hostLock = 1; hostWe = 1;
    for (int k = 0; k < 3; k++) begin
      hostAddr = AW'(k); hostWdata = wdat(k + 20);
      settle();
      checks++; if (hostGrant !== 1'b1) begin failures++; $display("FAIL midburst_grant_%0d got=%0b exp=1", k, hostGrant); end
      step();
    end
    reset = 1'b0; hostAddr = AW'(3); hostWdata = wdat(23);
    settle();
    checks++; if (hostGrant !== 1'b0 || memWe !== 1'b0) begin failures++; $display("FAIL midburst_reset hg=%0b we=%0b exp 0/0", hostGrant, memWe); end
    step();
    reset = 1'b1; cpuReq = 1; cpuAddr = AW'(8'h31);
    settle();
    checks++; if (hostGrant !== 1'b0 || cpuStall !== 1'b0) begin failures++; $display("FAIL midburst_abort hg=%0b cs=%0b exp 0/0", hostGrant, cpuStall); end
    step();
    hostReq = 0; cpuReq = 0;
    for (int a = 0; a < 3; a++) begin
      checks++; if (mem[a] !== wdat(a + 20)) begin failures++; $display("FAIL midburst_mem_%0d got=%h exp=%h", a, mem[a], wdat(a + 20)); end
    end
    checks++; if (mem[3] !== '0) begin failures++; $display("FAIL midburst_mem_3 got=%h exp=0", mem[3]); end
  endtask

  task automatic test_write_then_read();
    logic [WW-1:0] ones;
    ones = '1;
    reset = 1'b1; cpuReq = 0; hostReq = 1; hostWe = 1; hostLock = 0;
    hostAddr = AW'(8'h20); hostWdata = ones;
    settle();
    checks++; if (hostGrant !== 1'b1 || memWe !== 1'b1) begin failures++; $display("FAIL wr_grant hg=%0b we=%0b exp 1/1", hostGrant, memWe); end
    step();
    hostReq = 0; cpuReq = 1; cpuWe = 0; cpuAddr = AW'(8'h20);
    settle();
    checks++; if (cpuRdata !== ones || cpuStall !== 1'b0) begin failures++; $display("FAIL wr_cpu_read rd=%h cs=%0b", cpuRdata, cpuStall); end
    step();
    cpuReq = 0;
  endtask

  task automatic test_random();
    logic host_done;
    host_done = 1'b1;
    hostReq = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hostReq || host_done) begin
        hostReq   = ($urandom_range(0, 2) != 0);
        hostWe    = $urandom_range(0, 1);
        hostAddr  = AW'($urandom_range(0, 63));
        hostWdata = rand_word();
      end
      hostLock = ($urandom_range(0, 3) != 0);
      cpuReq   = $urandom_range(0, 1);
      cpuWe    = $urandom_range(0, 1);
      cpuAddr  = AW'($urandom_range(0, 63));
      cpuWdata = rand_word();
      reset    = ($urandom_range(0, 49) != 0);
      settle();
      checks++; if (hostGrant !== e_hg) begin failures++; $display("FAIL rnd_hostGrant c%0d got=%0b exp=%0b", c, hostGrant, e_hg); end
      checks++; if (cpuStall !== e_cs) begin failures++; $display("FAIL rnd_cpuStall c%0d got=%0b exp=%0b", c, cpuStall, e_cs); end
      checks++; if (memWe !== e_we) begin failures++; $display("FAIL rnd_memWe c%0d got=%0b exp=%0b", c, memWe, e_we); end
      checks++; if (memAddr !== e_addr) begin failures++; $display("FAIL rnd_memAddr c%0d got=%h exp=%h", c, memAddr, e_addr); end
      checks++; if (memWdata !== e_wd) begin failures++; $display("FAIL rnd_memWdata c%0d got=%h exp=%h", c, memWdata, e_wd); end
      checks++; if (cpuRdata !== e_crd) begin failures++; $display("FAIL rnd_cpuRdata c%0d got=%h exp=%h", c, cpuRdata, e_crd); end
      checks++; if (hostRvalid !== m_rv) begin failures++; $display("FAIL rnd_hostRvalid c%0d got=%0b exp=%0b", c, hostRvalid, m_rv); end
      checks++; if (hostRdata !== m_rd) begin failures++; $display("FAIL rnd_hostRdata c%0d got=%h exp=%h", c, hostRdata, m_rd); end
      host_done = e_hg;
      step();
    end
    reset = 1'b1; hostReq = 0; cpuReq = 0;
  endtask

  initial begin
    reset = 1'b0; cpuReq = 0; cpuWe = 0; cpuAddr = '0; cpuWdata = '0;
    hostReq = 0; hostLock = 0; hostWe = 0; hostAddr = '0; hostWdata = '0;
    m_wait = 0; m_bcnt = 0; m_burst = 0; m_rv = 1'b0; m_rd = '0;
    @(negedge clock);
    for (int a = 0; a < 256; a++) preload(a, rand_word());
    test_reset();
    test_contention();
    test_host_read();
    test_burst();
    test_reset_mid_burst();
    test_write_then_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
